// File: rtl/zet_fetch.sv
// Instruction prefetch stage: reads 16-bit code words over a Wishbone master port into a byte
// queue and hands bytes to the decoder one at a time, tracking the CS:IP of the head byte.
module zet_fetch #(
    parameter int unsigned QUEUE_DEPTH = 8,
    parameter logic [15:0] RESET_CS    = 16'hf000,
    parameter logic [15:0] RESET_IP    = 16'hfff0
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic        flush_i,
    input  logic [15:0] load_cs_i,
    input  logic [15:0] load_ip_i,
    output logic [18:0] wb_adr_o,
    output logic [1:0]  wb_sel_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic [15:0] wb_dat_i,
    input  logic        wb_ack_i,
    output logic [7:0]  instruction_o,
    output logic        instruction_valid_o,
    input  logic        next_instruction_i,
    output logic [15:0] instruction_cs_o,
    output logic [15:0] instruction_ip_o
);

    localparam int unsigned PtrW = $clog2(QUEUE_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    // Highest fill level that still leaves room for a full 2-byte word.
    localparam logic [CntW-1:0] MaxReqCount = CntW'(QUEUE_DEPTH - 2);

    typedef enum logic [1:0] {StIdle, StReq, StDiscard} state_e;

    state_e          state_q, state_d;
    logic            cyc_q, cyc_d;
    logic [18:0]     adr_q, adr_d;
    logic [15:0]     fcs_q, fcs_d;
    logic [15:0]     fip_q, fip_d;
    logic [15:0]     dip_q, dip_d;
    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;
    logic [7:0]      queue_q [QUEUE_DEPTH];

    logic [19:0]     phys;
    logic            valid;
    logic            pop;
    logic            take;
    logic [1:0]      npush;
    logic [7:0]      first_byte;

    always_comb begin
        phys       = {fcs_q, 4'h0} + {4'h0, fip_q};
        valid      = (count_q != '0);
        pop        = valid & next_instruction_i & ~flush_i;
        take       = (state_q == StReq) & wb_ack_i & ~flush_i;
        // An odd fetch IP only wants the high byte of the word.
        npush      = take ? (fip_q[0] ? 2'd1 : 2'd2) : 2'd0;
        first_byte = fip_q[0] ? wb_dat_i[15:8] : wb_dat_i[7:0];
    end

    always_comb begin
        fcs_d   = fcs_q;
        fip_d   = fip_q + 16'(npush);
        dip_d   = dip_q + 16'(pop);
        head_d  = head_q + PtrW'(pop);
        tail_d  = tail_q + PtrW'(npush);
        count_d = count_q + CntW'(npush) - CntW'(pop);
        if (flush_i) begin
            fcs_d   = load_cs_i;
            fip_d   = load_ip_i;
            dip_d   = load_ip_i;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        adr_d   = adr_q;
        unique case (state_q)
            StIdle: begin
                if (!flush_i && count_q <= MaxReqCount) begin
                    state_d = StReq;
                    cyc_d   = 1'b1;
                    adr_d   = phys[19:1];
                end
            end
            StReq: begin
                if (wb_ack_i) begin
                    state_d = StIdle;
                    cyc_d   = 1'b0;
                end else if (flush_i) begin
                    state_d = StDiscard;
                end
            end
            StDiscard: begin
                if (wb_ack_i) begin
                    state_d = StIdle;
                    cyc_d   = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
                cyc_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
            cyc_q   <= 1'b0;
            adr_q   <= '0;
            fcs_q   <= RESET_CS;
            fip_q   <= RESET_IP;
            dip_q   <= RESET_IP;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                queue_q[i] <= 8'h00;
            end
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            adr_q   <= adr_d;
            fcs_q   <= fcs_d;
            fip_q   <= fip_d;
            dip_q   <= dip_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (take) begin
                queue_q[tail_q] <= first_byte;
            end
            if (take && !fip_q[0]) begin
                queue_q[tail_q + PtrW'(1)] <= wb_dat_i[15:8];
            end
        end
    end

    assign wb_adr_o            = adr_q;
    assign wb_sel_o            = 2'b11;
    assign wb_cyc_o            = cyc_q;
    assign wb_stb_o            = cyc_q;
    assign instruction_valid_o = valid;
    assign instruction_o       = valid ? queue_q[head_q] : 8'h00;
    assign instruction_cs_o    = fcs_q;
    assign instruction_ip_o    = dip_q;

endmodule

// File: tb/tb_zet_fetch.sv
// Bench for zet_fetch: a byte-queue model checked every cycle, a Wishbone memory responder,
// and directed scenarios with hand-computed expectations.
module tb_zet_fetch;

    localparam int unsigned DEPTH = 8;

    logic        clk                = 1'b0;
    logic        rst_i              = 1'b0;
    logic        flush_i            = 1'b0;
    logic [15:0] load_cs_i          = 16'h0;
    logic [15:0] load_ip_i          = 16'h0;
    logic [18:0] wb_adr_o;
    logic [1:0]  wb_sel_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [15:0] wb_dat_i           = 16'h0;
    logic        wb_ack_i           = 1'b0;
    logic [7:0]  instruction_o;
    logic        instruction_valid_o;
    logic        next_instruction_i = 1'b0;
    logic [15:0] instruction_cs_o;
    logic [15:0] instruction_ip_o;

    always #5 clk = ~clk;

    zet_fetch #(
        .QUEUE_DEPTH(DEPTH),
        .RESET_CS   (16'hf000),
        .RESET_IP   (16'hfff0)
    ) dut (
        .clk                (clk),
        .rst_i              (rst_i),
        .flush_i            (flush_i),
        .load_cs_i          (load_cs_i),
        .load_ip_i          (load_ip_i),
        .wb_adr_o           (wb_adr_o),
        .wb_sel_o           (wb_sel_o),
        .wb_cyc_o           (wb_cyc_o),
        .wb_stb_o           (wb_stb_o),
        .wb_dat_i           (wb_dat_i),
        .wb_ack_i           (wb_ack_i),
        .instruction_o      (instruction_o),
        .instruction_valid_o(instruction_valid_o),
        .next_instruction_i (next_instruction_i),
        .instruction_cs_o   (instruction_cs_o),
        .instruction_ip_o   (instruction_ip_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory contents: word FFFF0 holds EAEA, everything else derives from the word address.
    function automatic logic [15:0] mem_word(input logic [18:0] a);
        logic [7:0] lo;
        logic [7:0] hi;
        if (a == 19'h7fff8) return 16'hEAEA;
        lo = a[7:0] ^ 8'h5a;
        hi = a[7:0] + 8'h31;
        return {hi, lo};
    endfunction

    // Wishbone responder: acks after wait_cycles of strobe.
    int wait_cycles = 0;
    int wcnt        = 0;
    int ack_count   = 0;
    always @(negedge clk) begin
        if (wb_cyc_o && !wb_ack_i) begin
            if (wcnt >= wait_cycles) begin
                wb_ack_i = 1'b1;
                wb_dat_i = mem_word(wb_adr_o);
                ack_count++;
            end else begin
                wcnt++;
            end
        end else begin
            wb_ack_i = 1'b0;
            wcnt     = 0;
        end
    end

    // Reference model: byte FIFO plus fetch/decode pointers and a bus-busy flag.
    logic [15:0] m_cs;
    logic [15:0] m_fip;
    logic [15:0] m_dip;
    logic [18:0] m_adr;
    bit          m_busy;
    bit          m_drop;
    logic [7:0]  mq[$];
    int unsigned m_sz;
    int unsigned m_ph;

    always @(posedge clk) begin
        if (!rst_i) begin
            m_cs   = 16'hf000;
            m_fip  = 16'hfff0;
            m_dip  = 16'hfff0;
            m_adr  = 19'h0;
            m_busy = 1'b0;
            m_drop = 1'b0;
            mq.delete();
        end else begin
            m_sz = mq.size();
            if (m_busy) begin
                if (wb_ack_i) begin
                    if (!m_drop && !flush_i) begin
                        if (m_fip[0]) begin
                            mq.push_back(wb_dat_i[15:8]);
                            m_fip = m_fip + 16'd1;
                        end else begin
                            mq.push_back(wb_dat_i[7:0]);
                            mq.push_back(wb_dat_i[15:8]);
                            m_fip = m_fip + 16'd2;
                        end
                    end
                    m_busy = 1'b0;
                    m_drop = 1'b0;
                end else if (flush_i) begin
                    m_drop = 1'b1;
                end
            end else if (!flush_i && (DEPTH - m_sz) >= 2) begin
                m_ph   = (32'(m_cs) * 16 + 32'(m_fip)) % 32'h100000;
                m_adr  = 19'(m_ph >> 1);
                m_busy = 1'b1;
            end
            if (!flush_i && next_instruction_i && m_sz > 0) begin
                void'(mq.pop_front());
                m_dip = m_dip + 16'd1;
            end
            if (flush_i) begin
                mq.delete();
                m_cs  = load_cs_i;
                m_fip = load_ip_i;
                m_dip = load_ip_i;
            end
        end
        #2;
        chk("cyc", wb_cyc_o, m_busy);
        chk("stb", wb_stb_o, m_busy);
        chk("sel", wb_sel_o, 2'b11);
        if (m_busy) chk("adr", wb_adr_o, m_adr);
        chk("valid", instruction_valid_o, mq.size() != 0);
        chk("instr", instruction_o, (mq.size() != 0) ? mq[0] : 8'h00);
        chk("ip", instruction_ip_o, m_dip);
        chk("cs", instruction_cs_o, m_cs);
    end

    task automatic wait_cyc(input string name);
        for (int i = 0; i < 60 && !wb_cyc_o; i++) @(negedge clk);
        chk({name, "_req"}, wb_cyc_o, 1'b1);
    endtask

    task automatic wait_no_cyc(input string name);
        for (int i = 0; i < 60 && wb_cyc_o; i++) @(negedge clk);
        chk({name, "_end"}, wb_cyc_o, 1'b0);
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 60 && !instruction_valid_o; i++) @(negedge clk);
        chk({name, "_valid"}, instruction_valid_o, 1'b1);
    endtask

    task automatic do_flush(input logic [15:0] cs, input logic [15:0] ip);
        @(negedge clk);
        flush_i   = 1'b1;
        load_cs_i = cs;
        load_ip_i = ip;
        @(negedge clk);
        flush_i   = 1'b0;
    endtask

    task automatic pop1();
        next_instruction_i = 1'b1;
        @(negedge clk);
        next_instruction_i = 1'b0;
    endtask

    logic [7:0] t6_bytes [4];

    initial begin
        t6_bytes[0] = 8'h5b;
        t6_bytes[1] = 8'h32;
        t6_bytes[2] = 8'h58;
        t6_bytes[3] = 8'h33;

        // Reset state, then first fetch from FFFF0.
        repeat (3) @(negedge clk);
        chk("rst_cyc", wb_cyc_o, 1'b0);
        chk("rst_valid", instruction_valid_o, 1'b0);
        chk("rst_instr", instruction_o, 8'h00);
        chk("rst_ip", instruction_ip_o, 16'hfff0);
        chk("rst_cs", instruction_cs_o, 16'hf000);
        rst_i = 1'b1;
        wait_cyc("t1");
        chk("t1_adr", wb_adr_o, 19'h7fff8);
        wait_valid("t1");
        chk("t1_b0", instruction_o, 8'hea);
        chk("t1_ip0", instruction_ip_o, 16'hfff0);
        pop1();
        chk("t1_b1", instruction_o, 8'hea);
        chk("t1_ip1", instruction_ip_o, 16'hfff1);
        repeat (30) @(negedge clk);

        // Odd flush target: exact latency and single high byte.
        do_flush(16'h1234, 16'h0005);
        chk("t2_cyc_n1", wb_cyc_o, 1'b0);
        chk("t2_valid_n1", instruction_valid_o, 1'b0);
        @(negedge clk);
        chk("t2_cyc_n2", wb_cyc_o, 1'b1);
        chk("t2_adr", wb_adr_o, 19'h091a2);
        @(negedge clk);
        chk("t2_valid_n3", instruction_valid_o, 1'b1);
        chk("t2_byte", instruction_o, 8'hd3);
        chk("t2_ip", instruction_ip_o, 16'h0005);
        chk("t2_cs", instruction_cs_o, 16'h1234);
        chk("t2_gap", wb_cyc_o, 1'b0);
        @(negedge clk);
        chk("t2_adr2", wb_adr_o, 19'h091a3);
        repeat (30) @(negedge clk);

        // No pops: exactly four word fetches fill the queue; an empty-queue pop is ignored.
        ack_count = 0;
        do_flush(16'h2000, 16'h0000);
        pop1();
        repeat (30) @(negedge clk);
        chk("t3_fetches", ack_count, 4);
        chk("t3_idle", wb_cyc_o, 1'b0);
        chk("t3_ip", instruction_ip_o, 16'h0000);
        pop1();
        repeat (6) @(negedge clk);
        chk("t3_one_pop", ack_count, 4);
        pop1();
        repeat (6) @(negedge clk);
        chk("t3_two_pop", ack_count, 5);
        repeat (10) @(negedge clk);

        // Flush during a slow bus cycle: the stale word is discarded.
        wait_cycles = 5;
        do_flush(16'h3000, 16'h0000);
        wait_cyc("t4");
        chk("t4_adr", wb_adr_o, 19'h18000);
        @(negedge clk);
        flush_i   = 1'b1;
        load_cs_i = 16'h4000;
        load_ip_i = 16'h0010;
        @(negedge clk);
        flush_i = 1'b0;
        chk("t4_hold", wb_cyc_o, 1'b1);
        wait_no_cyc("t4");
        wait_valid("t4");
        chk("t4_byte", instruction_o, 8'h52);
        chk("t4_ip", instruction_ip_o, 16'h0010);
        chk("t4_cs", instruction_cs_o, 16'h4000);
        wait_cycles = 0;
        repeat (40) @(negedge clk);

        // IP wrap at FFFE and physical wrap at 1 MB.
        do_flush(16'h0000, 16'hfffe);
        wait_cyc("t5a");
        chk("t5_adr_a", wb_adr_o, 19'h07fff);
        wait_no_cyc("t5a");
        wait_cyc("t5b");
        chk("t5_adr_b", wb_adr_o, 19'h00000);
        wait_valid("t5");
        chk("t5_b0", instruction_o, 8'ha5);
        chk("t5_ip0", instruction_ip_o, 16'hfffe);
        pop1();
        chk("t5_b1", instruction_o, 8'h30);
        chk("t5_ip1", instruction_ip_o, 16'hffff);
        pop1();
        chk("t5_b2", instruction_o, 8'h5a);
        chk("t5_ip2", instruction_ip_o, 16'h0000);
        repeat (30) @(negedge clk);
        do_flush(16'hffff, 16'h0010);
        wait_cyc("t5c");
        chk("t5_adr_c", wb_adr_o, 19'h00000);
        repeat (30) @(negedge clk);

        // Pop coincides with a 2-byte push while three bytes are queued.
        do_flush(16'h5000, 16'h0001);
        @(negedge clk);
        @(negedge clk);
        chk("t6_b0", instruction_o, 8'h31);
        chk("t6_ip0", instruction_ip_o, 16'h0001);
        repeat (3) @(negedge clk);
        chk("t6_cyc", wb_cyc_o, 1'b1);
        chk("t6_adr", wb_adr_o, 19'h28002);
        next_instruction_i = 1'b1;
        @(negedge clk);
        next_instruction_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("t6_order", instruction_o, t6_bytes[k]);
            chk("t6_ip", instruction_ip_o, 16'(2 + k));
            pop1();
        end
        repeat (30) @(negedge clk);

        // Asynchronous reset in the middle of a bus cycle.
        wait_cycles = 5;
        do_flush(16'h6000, 16'h0000);
        wait_cyc("t7");
        @(negedge clk);
        #1 rst_i = 1'b0;
        #1;
        chk("t7_cyc", wb_cyc_o, 1'b0);
        chk("t7_stb", wb_stb_o, 1'b0);
        chk("t7_valid", instruction_valid_o, 1'b0);
        chk("t7_ip", instruction_ip_o, 16'hfff0);
        chk("t7_cs", instruction_cs_o, 16'hf000);
        @(negedge clk);
        rst_i       = 1'b1;
        wait_cycles = 0;
        wait_cyc("t7b");
        chk("t7_adr", wb_adr_o, 19'h7fff8);
        wait_valid("t7");
        chk("t7_byte", instruction_o, 8'hea);
        repeat (5) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
